sweep_sequencer: RTL and testbench

Control-side initiator for the shared up/down `counter` used as an operand-address generator in the matrix-multiplier datapath. On a `start` command it drives the counter's `en`/`load`/`dn`/`data` inputs to sweep `len` consecutive addresses from `base`, upward or downward. It tracks the expected address internally and checks it against the counter's `count` feedback. It marks each valid address cycle, supports consumer back-pressure, and reports completion and mismatch errors.

---
 rtl/sweep_sequencer.sv | 140 ++++++++++++++
 tb/tb_sweep_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: control-side initiator for the shared up/down address counter.
// On start, loads the counter with base and steps it through len consecutive
// addresses (up or down), tracks the expected address and flags feedback errors.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, dir, base, len sweep request and its parameters (latched at start)
//   stall                consumer back-pressure, holds the current address
//   count                feedback from the counter's count output
//   cnt_en/load/dn/data  drive the counter's en/load/dn/data inputs
//   addr_valid           count holds a sweep address this cycle
//   busy                 high in LOAD and RUN
//   done                 one-cycle completion pulse
//   err                  sticky feedback-mismatch flag
module sweep_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] len,
    input  logic             stall,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic             cnt_dn,
    output logic [WIDTH-1:0] cnt_data,
    output logic             addr_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= ZERO;
            len_q   <= ZERO;
            exp_q   <= ZERO;
            rem_q   <= ZERO;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len != ZERO) begin
                        base_d  = base;
                        len_d   = len;
                        dir_d   = dir;
                        state_d = S_LOAD;
                    end else begin
                        // Empty sweep: no counter activity, just the done pulse
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                rem_d   = len_q;
                exp_d   = base_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    rem_d = rem_q - ONE;
                    // Modulo-2^WIDTH wrap mirrors the counter's own wrap
                    exp_d = dir_q ? (exp_q - ONE) : (exp_q + ONE);
                    if (rem_q == ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Feedback check while the counter is expected to hold a sweep address
        if (state_q == S_RUN && count != exp_q) begin
            err_d = 1'b1;
        end
    end

    // Counter is never stepped past the last address (rem_q == 1)
    assign cnt_en     = (state_q == S_LOAD) ||
                        ((state_q == S_RUN) && !stall && (rem_q != ONE));
    assign cnt_load   = (state_q == S_LOAD);
    assign cnt_dn     = dir_q;
    assign cnt_data   = base_q;
    assign addr_valid = (state_q == S_RUN);
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Table-driven bench for sweep_sequencer with a behavioural up/down counter
// closing the feedback loop.
module tb_sweep_sequencer;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] len;
    logic             stall;
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             cnt_load;
    logic             cnt_dn;
    logic [WIDTH-1:0] cnt_data;
    logic             addr_valid;
    logic             busy;
    logic             done;
    logic             err;

    logic             frc;
    logic [WIDTH-1:0] fval;
    logic [WIDTH-1:0] ctr_q;

    int n_tests;
    int n_fail;

    sweep_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .base       (base),
        .len        (len),
        .stall      (stall),
        .count      (count),
        .cnt_en     (cnt_en),
        .cnt_load   (cnt_load),
        .cnt_dn     (cnt_dn),
        .cnt_data   (cnt_data),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared up/down counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr_q <= '0;
        end else if (cnt_en) begin
            if (cnt_load) ctr_q <= cnt_data;
            else if (cnt_dn) ctr_q <= ctr_q - 4'd1;
            else ctr_q <= ctr_q + 4'd1;
        end
    end

    assign count = frc ? fval : ctr_q;

    // Expected output bundle: {en, load, dn, data[3:0], addr_valid, busy, done, err}
    typedef struct {
        logic        rst_n;
        logic        start;
        logic        dir;
        logic [3:0]  base;
        logic [3:0]  len;
        logic        stall;
        logic        frc;
        logic [3:0]  fval;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] o(input logic en, input logic ld, input logic dn,
                                      input logic [3:0] data, input logic av,
                                      input logic bz, input logic dne, input logic er);
        return {en, ld, dn, data, av, bz, dne, er};
    endfunction

    task automatic v(input logic r, input logic s, input logic d, input logic [3:0] b,
                     input logic [3:0] l, input logic st, input logic fr,
                     input logic [3:0] fv, input logic [10:0] e);
        vec_t x;
        x.rst_n = r; x.start = s; x.dir = d; x.base = b; x.len = l;
        x.stall = st; x.frc = fr; x.fval = fv; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    logic [10:0] act;
    int          av_cnt;
    int          en_cnt;
    int          done_cyc;
    logic        err_seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; base = '0; len = '0;
        stall = 1'b0; frc = 1'b0; fval = '0;
        repeat (2) @(negedge clk);

        // Reset state
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 0,0,0,0,0));
        // Up sweep base=3 len=4
        v(1,1,0, 3,4,0,0,0, o(0,0,0, 0,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,1,0, 3,0,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 3,0,0,1,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 3,0,0,0,0));
        // Down sweep base=1 len=3 with wrap; start in RUN and in DONE ignored
        v(1,1,1, 1,3,0,0,0, o(0,0,0, 3,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,1,1, 1,0,1,0,0));
        v(1,1,0, 9,5,0,0,0, o(1,0,1, 1,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,1, 1,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,1, 1,1,1,0,0));
        v(1,1,0, 6,2,0,0,0, o(0,0,1, 1,0,0,1,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,1, 1,0,0,0,0));
        // Stall: base=8 len=3, two stalled cycles on the 2nd address
        v(1,1,0, 8,3,0,0,0, o(0,0,1, 1,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,1,0, 8,0,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 8,1,1,0,0));
        v(1,0,0, 0,0,1,0,0, o(0,0,0, 8,1,1,0,0));
        v(1,0,0, 0,0,1,0,0, o(0,0,0, 8,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 8,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 8,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 8,0,0,1,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 8,0,0,0,0));
        // Empty sweep: done next cycle, nothing latched
        v(1,1,1, 5,0,0,0,0, o(0,0,0, 8,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 8,0,0,1,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 8,0,0,0,0));
        // Mismatch: count forced to 7 while 5 expected
        v(1,1,0, 3,4,0,0,0, o(0,0,0, 8,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,1,0, 3,0,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,1,7, o(1,0,0, 3,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 3,1,1,0,1));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 3,0,0,1,1));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 3,0,0,0,1));
        v(1,1,0, 2,1,0,0,0, o(0,0,0, 3,0,0,0,1));
        v(1,0,0, 0,0,0,0,0, o(1,1,0, 2,0,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 2,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 2,0,0,1,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 2,0,0,0,0));
        // Reset during the 2nd address, then an up sweep wrapping 14,15,0
        v(1,1,0, 4,3,0,0,0, o(0,0,0, 2,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,1,0, 4,0,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0, 4,1,1,0,0));
        v(0,0,0, 0,0,0,0,0, o(1,0,0, 4,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 0,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0, 0,0,0,0,0));
        v(1,1,0,14,3,0,0,0, o(0,0,0, 0,0,0,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,1,0,14,0,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0,14,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(1,0,0,14,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0,14,1,1,0,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0,14,0,0,1,0));
        v(1,0,0, 0,0,0,0,0, o(0,0,0,14,0,0,0,0));

        // Drive each vector mid-cycle, sample 1 time unit later
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; start = vecs[i].start; dir = vecs[i].dir;
            base = vecs[i].base; len = vecs[i].len; stall = vecs[i].stall;
            frc = vecs[i].frc; fval = vecs[i].fval;
            #1;
            act = {cnt_en, cnt_load, cnt_dn, cnt_data, addr_valid, busy, done, err};
            check($sformatf("vec%0d", i), int'(act), int'(vecs[i].exp));
        end

        // Maximum-length down sweep from 0: 15 addresses, 1 load + 14 steps
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; dir = 1'b1; base = 4'd0; len = 4'd15;
        stall = 1'b0; frc = 1'b0;
        av_cnt = 0; en_cnt = 0; done_cyc = -1; err_seen = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (addr_valid) av_cnt++;
            if (cnt_en) en_cnt++;
            if (err) err_seen = 1'b1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("max_done_latency", done_cyc, 17);
        check("max_addr_valid_cycles", av_cnt, 15);
        check("max_cnt_en_cycles", en_cnt, 15);
        check("max_err", int'(err_seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
